// File: rtl/fifo_ptr_ctrl_if.sv
// Handshake and status bundle between a FIFO user and the pointer controller.
// The master side issues write/read/flush requests; the slave side (the
// controller) returns storage addresses, accepted strobes and status flags.
interface fifo_ptr_ctrl_if #(
  parameter int DEPTH      = 4,
  parameter int PTR_LENGTH = $clog2(DEPTH),
  parameter int CNT_LENGTH = $clog2(DEPTH + 1)
);

  logic                  write;
  logic                  read;
  logic                  flush;
  logic [PTR_LENGTH-1:0] wptr;
  logic [PTR_LENGTH-1:0] rptr;
  logic                  fifo_write;
  logic                  fifo_read;
  logic [CNT_LENGTH-1:0] count;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write, read, flush,
    input  wptr, rptr, fifo_write, fifo_read, count,
           empty, full, almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  write, read, flush,
    output wptr, rptr, fifo_write, fifo_read, count,
           empty, full, almost_empty, almost_full, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer controller: pairs a read and a write pointer over a
// DEPTH-entry dual-port array, tracks occupancy and derives status flags,
// gated storage enables, a synchronous flush and sticky error flags.
// DEPTH need not be a power of two, so pointers wrap explicitly at DEPTH-1.
module fifo_ptr_ctrl #(
  parameter int DEPTH      = 4,
  parameter int PTR_LENGTH = $clog2(DEPTH),
  parameter int CNT_LENGTH = $clog2(DEPTH + 1),
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                clk,
  input  logic                reset,
  fifo_ptr_ctrl_if.slave      bus
);

  localparam logic [PTR_LENGTH-1:0] PTR_LAST = PTR_LENGTH'(DEPTH - 1);
  localparam logic [CNT_LENGTH-1:0] CNT_FULL = CNT_LENGTH'(DEPTH);
  localparam logic [CNT_LENGTH-1:0] CNT_AF   = CNT_LENGTH'(AF_LEVEL);
  localparam logic [CNT_LENGTH-1:0] CNT_AE   = CNT_LENGTH'(AE_LEVEL);
  localparam logic [CNT_LENGTH-1:0] CNT_ONE  = CNT_LENGTH'(1);
  localparam logic [PTR_LENGTH-1:0] PTR_ONE  = PTR_LENGTH'(1);

  logic [PTR_LENGTH-1:0] wptr_q, wptr_d;
  logic [PTR_LENGTH-1:0] rptr_q, rptr_d;
  logic [CNT_LENGTH-1:0] count_q, count_d;
  logic                  overflow_q, underflow_q;

  logic empty, full;
  logic accept_write, accept_read;
  logic reject_write, reject_read;

  // Status decoded from the registered count, so flags describe the state
  // left by the last clock edge.
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CNT_FULL);
  end

  // Accept decisions: a write into a full FIFO is legal only alongside a read
  // (full implies non-empty, so that read is always accepted). Flush and
  // reset suppress both strobes so the array is never touched while clearing.
  always_comb begin
    accept_read  = bus.read  & ~empty & ~bus.flush & ~reset;
    accept_write = bus.write & (~full | bus.read) & ~bus.flush & ~reset;
    reject_write = bus.write & ~accept_write & ~bus.flush;
    reject_read  = bus.read  & empty & ~bus.flush;
  end

  // Next pointer and occupancy values; pointers wrap explicitly because DEPTH
  // may not fill the pointer width.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (accept_write) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_ONE;
    end
    if (accept_read) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_ONE;
    end
    case ({accept_write, accept_read})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State register: reset beats flush, flush beats normal traffic. Error
  // flags are sticky and only reset or flush clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_q  | reject_write;
      underflow_q <= underflow_q | reject_read;
    end
  end

  // Drive the interface outputs from registered state and the accept logic.
  always_comb begin
    bus.wptr         = wptr_q;
    bus.rptr         = rptr_q;
    bus.count        = count_q;
    bus.fifo_write   = accept_write;
    bus.fifo_read    = accept_read;
    bus.empty        = empty;
    bus.full         = full;
    bus.almost_full  = (count_q >= CNT_AF);
    bus.almost_empty = (count_q <= CNT_AE);
    bus.overflow     = overflow_q;
    bus.underflow    = underflow_q;
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed testbench for fifo_ptr_ctrl with DEPTH=5 (AF_LEVEL=4, AE_LEVEL=1).
// Inputs change 1ns after each rising edge; outputs are sampled 1ns later,
// well clear of the next edge.
module tb_fifo_ptr_ctrl;

  localparam int DEPTH = 5;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  fifo_ptr_ctrl_if #(.DEPTH(DEPTH)) bus ();

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running 10ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive request inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic w, input logic r, input logic f, input logic rs);
    bus.write = w;
    bus.read  = r;
    bus.flush = f;
    reset     = rs;
    #1;
  endtask

  // Advance one clock edge and park 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check every registered output plus the status flags against expectations.
  task automatic checkState(input string tag, input int w, input int r, input int c,
                            input int ovf, input int unf);
    checkOutput({tag, " wptr"}, bus.wptr, w);
    checkOutput({tag, " rptr"}, bus.rptr, r);
    checkOutput({tag, " count"}, bus.count, c);
    checkOutput({tag, " empty"}, bus.empty, (c == 0) ? 1 : 0);
    checkOutput({tag, " full"}, bus.full, (c == DEPTH) ? 1 : 0);
    checkOutput({tag, " almost_full"}, bus.almost_full, (c >= 4) ? 1 : 0);
    checkOutput({tag, " almost_empty"}, bus.almost_empty, (c <= 1) ? 1 : 0);
    checkOutput({tag, " overflow"}, bus.overflow, ovf);
    checkOutput({tag, " underflow"}, bus.underflow, unf);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    bus.write  = 1'b0;
    bus.read   = 1'b0;
    bus.flush  = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;

    // Reset cycle with a read request: no accept strobes while in reset.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("reset fifo_read", bus.fifo_read, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("after reset", 0, 0, 0, 0, 0);

    // Five writes: wptr 1,2,3,4,0; almost_full from count 4; full at 5.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("fill fifo_write", bus.fifo_write, 1);
      tick();
      checkState("fill", (i + 1) % DEPTH, 0, i + 1, 0, 0);
    end

    // Sixth write while full with no read: rejected, overflow sticks.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("overflow fifo_write", bus.fifo_write, 0);
    tick();
    checkState("overflow", 0, 0, 5, 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("overflow sticky", bus.overflow, 1);

    // Full: 12 cycles of read+write keep count at 5; both pointers end at 2.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("full rw fifo_write", bus.fifo_write, 1);
      checkOutput("full rw fifo_read", bus.fifo_read, 1);
      tick();
      checkOutput("full rw count", bus.count, 5);
      checkOutput("full rw full", bus.full, 1);
    end
    checkState("full rw end", 2, 2, 5, 1, 0);

    // Flush clears pointers, count and the overflow flag.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("flush", 0, 0, 0, 0, 0);

    // Empty: read alone is rejected and raises underflow.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("empty read fifo_read", bus.fifo_read, 0);
    tick();
    checkState("empty read", 0, 0, 0, 0, 1);

    // Empty: read+write accepts only the write; no fall-through.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("empty rw fifo_write", bus.fifo_write, 1);
    checkOutput("empty rw fifo_read", bus.fifo_read, 0);
    tick();
    checkState("empty rw", 1, 0, 1, 0, 1);

    // One more write takes count to 2, where almost_empty drops.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkState("count two", 2, 0, 2, 0, 1);

    // One read: count 1, rptr 1.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("read fifo_read", bus.fifo_read, 1);
    tick();
    checkState("read one", 2, 1, 1, 0, 1);

    // Bring count to 3, then flush together with read and write.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    checkState("pre flush", 4, 1, 3, 0, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("flush rw fifo_write", bus.fifo_write, 0);
    checkOutput("flush rw fifo_read", bus.fifo_read, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("flush rw", 0, 0, 0, 0, 0);

    // Build count 3 with rptr offset, then reset mid-burst.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkState("pre reset", 4, 1, 3, 0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("reset rw fifo_read", bus.fifo_read, 0);
    checkOutput("reset rw fifo_write", bus.fifo_write, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("mid reset", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
